// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - size encodings, FSM state type and lane helpers for mem_responder
package mem_resp_pkg;

    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unknown size codes fall through to the word case.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lo;
            SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: lane_data = {4{wdata[7:0]}};
            SZ_HALF: lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lo[0];
            default: misaligned = |lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// rtl/mem_resp_ram.sv - byte-enabled 32-bit word storage with registered read port
module mem_resp_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with fixed latency
// Optional misalignment reporting: define MEM_RESP_ALIGN_CHECK_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int AW      = 8,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic        valid,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam logic [3:0] LAT = LATENCY[3:0];

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW+1:0] addr_q;
    logic [2:0]    size_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic          ready_q;

    logic          capture;
    logic          enter_resp;
    logic [AW-1:0] rd_idx;
    logic          commit_ok;
    logic [3:0]    ram_we;
    logic          unused_addr;

    assign unused_addr = ^addr[31:AW+2];

    always_comb begin
        capture    = (state_q == IDLE) && valid;
        enter_resp = (capture && (LAT == 4'd0)) || ((state_q == WAIT) && (cnt_q == 4'd1));
        // With zero latency the read is issued on the capture edge itself.
        rd_idx     = capture ? addr[AW+1:2] : addr_q[AW+1:2];
        ram_we     = 4'b0000;
        if ((state_q == RESP) && write_q && commit_ok && !rst) begin
            ram_we = lane_mask(size_q, addr_q[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            write_q <= 1'b0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= enter_resp;
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        addr_q  <= addr[AW+1:0];
                        size_q  <= size;
                        write_q <= write;
                        wdata_q <= wdata;
                        cnt_q   <= LAT;
                        state_q <= (LAT == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_RESP_ALIGN_CHECK_EN
    logic err_q;
    logic req_misal;

    always_comb begin
        req_misal = capture ? misaligned(size, addr[1:0]) : misaligned(size_q, addr_q[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= enter_resp && req_misal;
        end
    end

    assign err       = err_q;
    assign commit_ok = !err_q;
`else
    assign err       = 1'b0;
    assign commit_ok = 1'b1;
`endif

    mem_resp_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (addr_q[AW+1:2]),
        .wdata (lane_data(size_q, wdata_q)),
        .re    (enter_resp),
        .raddr (rd_idx),
        .rdata (rdata)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder at latencies 0, 1 and 3
module tb_mem_responder;
    import mem_resp_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] addr_s  [3];
    logic [2:0]  size_s  [3];
    logic        valid_s [3];
    logic        write_s [3];
    logic [31:0] wdata_s [3];
    logic [31:0] rdata_s [3];
    logic        ready_s [3];
    logic        err_s   [3];

    int checks;
    int errors;

    mem_responder #(.AW(8), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .addr(addr_s[0]), .size(size_s[0]), .valid(valid_s[0]),
        .write(write_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0])
    );
    mem_responder #(.AW(8), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .addr(addr_s[1]), .size(size_s[1]), .valid(valid_s[1]),
        .write(write_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1])
    );
    mem_responder #(.AW(8), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .addr(addr_s[2]), .size(size_s[2]), .valid(valid_s[2]),
        .write(write_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]), .err(err_s[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction; request inputs are scrambled right after capture.
    task automatic do_req(input int d, input logic wr, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        addr_s[d] = a; size_s[d] = sz; write_s[d] = wr; wdata_s[d] = wd; valid_s[d] = 1'b1;
        @(posedge clk); #1;
        valid_s[d] = 1'b0; addr_s[d] = ~a; wdata_s[d] = ~wd; size_s[d] = 3'd0; write_s[d] = ~wr;
        lat = 0;
        while (!ready_s[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata_s[d];
        e  = err_s[d];
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ready_s[d] !== 1'b0 || rdata_s[d] !== 32'd0 || err_s[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: ready=%b rdata=%h err=%b, required 0/00000000/0",
                         d, ready_s[d], rdata_s[d], err_s[d]);
            end
        end
    endtask

    task automatic test_word;
        int lat; logic [31:0] rd; logic e;
        do_req(1, 1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF, lat, rd, e);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL word_store_latency: %0d, required 1", lat); end
        do_req(1, 1'b0, SZ_WORD, 32'h10, 32'h0, lat, rd, e);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL word_load_latency: %0d, required 1", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_data: %h, required deadbeef", rd); end
    endtask

    task automatic test_lanes;
        int lat; logic [31:0] rd; logic e;
        do_req(1, 1'b1, SZ_WORD, 32'h20, 32'h00000000, lat, rd, e);
        do_req(1, 1'b1, SZ_BYTE, 32'h23, 32'hFFFFFFAB, lat, rd, e);
        do_req(1, 1'b1, SZ_HALF, 32'h21, 32'hFFFF1234, lat, rd, e);
        checks++;
        if (rd !== 32'hAB000000) begin errors++; $display("FAIL store_prewrite_rdata: %h, required ab000000", rd); end
        do_req(1, 1'b0, SZ_WORD, 32'h20, 32'h0, lat, rd, e);
        checks++;
        if (rd !== 32'hAB001234) begin errors++; $display("FAIL lane_merge: %h, required ab001234", rd); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd; logic e; logic exp_rdy;
        do_req(0, 1'b1, SZ_WORD, 32'h8, 32'h0BADF00D, lat, rd, e);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL lat0_latency: %0d, required 0", lat); end
        @(negedge clk);
        addr_s[0] = 32'h8; size_s[0] = SZ_WORD; write_s[0] = 1'b0; valid_s[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            exp_rdy = (c == 0 || c == 2);
            if (c == 3) valid_s[0] = 1'b0;
            checks++;
            if (ready_s[0] !== exp_rdy) begin
                errors++;
                $display("FAIL b2b_ready[cycle %0d]: %b, required %b", c + 1, ready_s[0], exp_rdy);
            end
            if (exp_rdy) begin
                checks++;
                if (rdata_s[0] !== 32'h0BADF00D) begin
                    errors++;
                    $display("FAIL b2b_rdata[cycle %0d]: %h, required 0badf00d", c + 1, rdata_s[0]);
                end
            end
        end
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] rd; logic e;
        do_req(1, 1'b1, SZ_WORD, 32'h0, 32'h00000000, lat, rd, e);
        do_req(1, 1'b1, SZ_BYTE, 32'h400, 32'h00000055, lat, rd, e);
        do_req(1, 1'b0, SZ_WORD, 32'h000, 32'h0, lat, rd, e);
        checks++;
        if (rd !== 32'h00000055) begin errors++; $display("FAIL addr_wrap: %h, required 00000055", rd); end
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] rd; logic e; int seen;
        do_req(2, 1'b1, SZ_WORD, 32'h40, 32'h22222222, lat, rd, e);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL lat3_latency: %0d, required 3", lat); end
        @(negedge clk);
        addr_s[2] = 32'h40; size_s[2] = SZ_WORD; write_s[2] = 1'b1; wdata_s[2] = 32'h11111111; valid_s[2] = 1'b1;
        @(posedge clk); #1;
        valid_s[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ready_s[2]) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_ready: %0d pulses, required 0", seen); end
        checks++;
        if (rdata_s[2] !== 32'd0) begin errors++; $display("FAIL abort_rdata_reset: %h, required 00000000", rdata_s[2]); end
        do_req(2, 1'b0, SZ_WORD, 32'h40, 32'h0, lat, rd, e);
        checks++;
        if (rd !== 32'h22222222) begin errors++; $display("FAIL abort_no_commit: %h, required 22222222", rd); end
    endtask

    task automatic test_align;
        int lat; logic [31:0] rd; logic e; logic exp_err; logic [31:0] exp_word;
`ifdef MEM_RESP_ALIGN_CHECK_EN
        exp_err = 1'b1; exp_word = 32'h33333333;
`else
        exp_err = 1'b0; exp_word = 32'h44444444;
`endif
        do_req(1, 1'b1, SZ_WORD, 32'h40, 32'h33333333, lat, rd, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL aligned_err: %b, required 0", e); end
        do_req(1, 1'b1, SZ_WORD, 32'h42, 32'h44444444, lat, rd, e);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL misaligned_latency: %0d, required 1", lat); end
        checks++;
        if (e !== exp_err) begin errors++; $display("FAIL misaligned_err: %b, required %b", e, exp_err); end
        checks++;
        if (err_s[1] !== 1'b0) begin errors++; $display("FAIL err_after_resp: %b, required 0", err_s[1]); end
        do_req(1, 1'b0, SZ_WORD, 32'h40, 32'h0, lat, rd, e);
        checks++;
        if (rd !== exp_word) begin errors++; $display("FAIL misaligned_store_word: %h, required %h", rd, exp_word); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            addr_s[d] = 32'd0; size_s[d] = 3'd0; valid_s[d] = 1'b0; write_s[d] = 1'b0; wdata_s[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        test_word;
        test_lanes;
        test_back_to_back;
        test_wrap;
        test_reset_abort;
        test_align;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
